// File: rtl/uart_byte_tx_pkg.sv
// Shared definitions for the UART byte transmitter/receiver pair: FSM state codes,
// parity modes and the baud divisor derivation so both directions agree on bit timing.
package uart_byte_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Integer divide: the bit period is truncated, never rounded, so rx and tx stay identical.
    function automatic int calc_baud_div(input int clock_freq, input int baud);
        return clock_freq / baud;
    endfunction

    function automatic bit parity_enabled(input int mode);
        return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
    endfunction

    function automatic logic parity_bit(input int mode, input logic [7:0] data);
        logic w_bit;
        case (mode)
            PARITY_ODD:  w_bit = ~^data;
            PARITY_EVEN: w_bit = ^data;
            PARITY_NONE: w_bit = 1'b0;
            default:     w_bit = 1'b0;
        endcase
        return w_bit;
    endfunction

endpackage

// File: rtl/uart_byte_tx_baud_cnt.sv
// Bit-period counter: runs 0..BAUD_DIV-1 while enabled and flags the last clock of each bit.
module uart_byte_tx_baud_cnt #(
    parameter int BAUD_DIV = 434
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_count;

    assign o_bit_end = i_enable && (r_count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_bit_end ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// The line is driven straight from a flop so it never glitches.
module uart_byte_tx
    import uart_byte_tx_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Send_Go,
    input  logic [7:0] Data,
    output logic       uart_tx,
    output logic       Tx_Busy,
    output logic       Tx_Done
);

    localparam int BAUD_DIV   = calc_baud_div(CLOCK_FREQ, BAUD);
    localparam bit HAS_PARITY = parity_enabled(PARITY);
    localparam bit TWO_STOP   = (STOP_BITS == 2);

    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_parity;
    logic       r_stopcnt;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;

    logic w_accept;
    logic w_cnt_en;
    logic w_bit_end;

    assign w_accept = Send_Go && !r_busy;
    assign w_cnt_en = (r_state != ST_IDLE);

    uart_byte_tx_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .i_clk     (Clk),
        .i_rst_n   (Reset_n),
        .i_enable  (w_cnt_en),
        .i_clear   (!w_cnt_en),
        .o_bit_end (w_bit_end)
    );

    // Every state change happens on a bit boundary, and the next line level is loaded
    // on that same edge, so each bit lasts exactly BAUD_DIV clocks.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_parity  <= 1'b0;
            r_stopcnt <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_shift   <= Data;
                        r_parity  <= parity_bit(PARITY, Data);
                        r_bitcnt  <= 3'd0;
                        r_stopcnt <= 1'b0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == 3'd7) begin
                            if (HAS_PARITY) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (TWO_STOP && !r_stopcnt) begin
                            r_stopcnt <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_tx = r_tx;
    assign Tx_Busy = r_busy;
    assign Tx_Done = r_done;

endmodule
